// File: rtl/eigen_reconstruct_if.sv
// Request/result bundle for eigen_reconstruct: eigen inputs, start handshake, busy/done and the rebuilt matrix.
interface eigen_reconstruct_if #(
  parameter int N_STOCKS = 2,
  parameter int WIDTH    = 16
);
  logic                                           start;
  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]   eigenvectors;
  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]   eigenvalues;
  logic                                           busy;
  logic                                           done;
  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0]   matrix;

  modport master (output start, eigenvectors, eigenvalues, input busy, done, matrix);
  modport slave  (input start, eigenvectors, eigenvalues, output busy, done, matrix);
endinterface

// File: rtl/eigen_reconstruct.sv
// Rebuilds A = V*D*V^T in signed fixed point with one time-multiplexed multiplier.
// SCALE forms P = V*D row-major, ACCUM sums P[i][k]*V[j][k] over k for every (i,j).
module eigen_reconstruct #(
  parameter int N_STOCKS = 2,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8
) (
  input  logic               clk,
  input  logic               rst,
  eigen_reconstruct_if.slave bus
);
  localparam int CW   = $clog2(N_STOCKS);
  localparam int PW   = 2*WIDTH;
  localparam int ACCW = 2*WIDTH + CW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCALE = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(N_STOCKS-1);

  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] mat_t;

  logic [1:0]                       state;
  logic [CW-1:0]                    ci, cj, ck;
  mat_t                             v_r, p_r, mat_r;
  logic [N_STOCKS-1:0][WIDTH-1:0]   lam_r;
  logic signed [ACCW-1:0]           acc;

  logic signed [WIDTH-1:0]          op_a, op_b;
  logic signed [PW-1:0]             prod;
  logic signed [ACCW-1:0]           prod_x, acc_base, acc_sum;
  logic [WIDTH-1:0]                 p_sat, a_sat;

  function automatic logic [WIDTH-1:0] sat(input logic signed [ACCW-1:0] x);
    if (x > MAXV)      return MAXV[WIDTH-1:0];
    else if (x < MINV) return MINV[WIDTH-1:0];
    else               return x[WIDTH-1:0];
  endfunction

  // Operand mux for the single shared multiplier.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == S_SCALE) begin
      op_a = v_r[ci][ck];
      op_b = lam_r[ck];
    end else begin
      op_a = p_r[ci][ck];
      op_b = v_r[cj][ck];
    end
  end

  assign prod     = PW'(op_a) * PW'(op_b);
  assign prod_x   = ACCW'(prod);
  assign acc_base = (ck == '0) ? '0 : acc;
  assign acc_sum  = acc_base + prod_x;
  assign p_sat    = sat(prod_x >>> FRAC);
  assign a_sat    = sat(acc_sum >>> FRAC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      ci    <= '0;
      cj    <= '0;
      ck    <= '0;
      v_r   <= '0;
      p_r   <= '0;
      lam_r <= '0;
      mat_r <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            v_r <= bus.eigenvectors;
            for (int k = 0; k < N_STOCKS; k++) lam_r[k] <= bus.eigenvalues[k][k];
            ci    <= '0;
            cj    <= '0;
            ck    <= '0;
            state <= S_SCALE;
          end
        end
        S_SCALE: begin
          p_r[ci][ck] <= p_sat;
          if (ck == LAST) begin
            ck <= '0;
            if (ci == LAST) begin
              ci    <= '0;
              state <= S_ACCUM;
            end else begin
              ci <= ci + 1'b1;
            end
          end else begin
            ck <= ck + 1'b1;
          end
        end
        S_ACCUM: begin
          acc <= acc_sum;
          // Entry becomes visible as soon as its last product lands.
          if (ck == LAST) begin
            mat_r[ci][cj] <= a_sat;
            ck <= '0;
            if (cj == LAST) begin
              cj <= '0;
              if (ci == LAST) begin
                ci    <= '0;
                state <= S_DONE;
              end else begin
                ci <= ci + 1'b1;
              end
            end else begin
              cj <= cj + 1'b1;
            end
          end else begin
            ck <= ck + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.matrix = mat_r;

  // Off-diagonal eigenvalue entries are deliberately not consumed.
  logic unused_offdiag;
  assign unused_offdiag = ^bus.eigenvalues;
endmodule

// File: tb/tb_eigen_reconstruct.sv
// Scoreboard bench for eigen_reconstruct (N=2, Q8.8): results queued at start, checked at done.
module tb_eigen_reconstruct;
  typedef logic [1:0][1:0][15:0] mat_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  mat_t exp_q[$];

  eigen_reconstruct_if #(.N_STOCKS(2), .WIDTH(16)) bus ();

  eigen_reconstruct #(.N_STOCKS(2), .WIDTH(16), .FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mat_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
    mat_t m;
    m[0][0] = a; m[0][1] = b; m[1][0] = c; m[1][1] = d;
    return m;
  endfunction

  function automatic logic [15:0] tsat(input longint x);
    if (x > 32767)  return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  // Reference for random stimulus: plain integer arithmetic of V*D*V^T with the stated saturation.
  function automatic mat_t model(input mat_t v, input mat_t l);
    longint p[2][2];
    longint s;
    mat_t   a;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++)
        p[i][k] = longint'($signed(tsat((longint'($signed(v[i][k])) *
                                         longint'($signed(l[k][k]))) >>> 8)));
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += p[i][k] * longint'($signed(v[j][k]));
        a[i][j] = tsat(s >>> 8);
      end
    return a;
  endfunction

  task automatic start_run(input mat_t v, input mat_t l);
    @(negedge clk);
    bus.eigenvectors = v;
    bus.eigenvalues  = l;
    bus.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start        = 1'b0;
    bus.eigenvectors = ~v;
    bus.eigenvalues  = ~l;
  endtask

  // Called just after the start edge; lat counts edges up to the one that raises done.
  task automatic wait_done(output int lat, output logic pulse_ok);
    lat      = -1;
    pulse_ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_ok = (bus.done === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_cmp++; if (bus.matrix !== '0) begin n_bad++; $display("FAIL reset_matrix got %h exp 0", bus.matrix); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_identity();
    int lat; logic pok; mat_t e;
    exp_q.push_back(mk(16'h0200, 16'h0000, 16'h0000, 16'h0300));
    start_run(mk(16'h0100, 16'h0000, 16'h0000, 16'h0100), mk(16'h0200, 16'h0000, 16'h0000, 16'h0300));
    wait_done(lat, pok);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL identity_latency got %0d exp 12", lat); end
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL identity_pulse got %b exp 1", pok); end
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (bus.matrix[i][j] !== e[i][j]) begin
          n_bad++; $display("FAIL identity A[%0d][%0d] got %h exp %h", i, j, bus.matrix[i][j], e[i][j]);
        end
      end
  endtask

  task automatic test_rotation();
    int lat; logic pok; mat_t e;
    exp_q.push_back(mk(16'h02FF, 16'h00FF, 16'h00FF, 16'h02FF));
    start_run(mk(16'h00B5, 16'hFF4B, 16'h00B5, 16'h00B5), mk(16'h0400, 16'h0000, 16'h0000, 16'h0200));
    wait_done(lat, pok);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL rotation_latency got %0d exp 12", lat); end
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (bus.matrix[i][j] !== e[i][j]) begin
          n_bad++; $display("FAIL rotation A[%0d][%0d] got %h exp %h", i, j, bus.matrix[i][j], e[i][j]);
        end
      end
  endtask

  task automatic test_saturation();
    int lat; logic pok; mat_t e;
    logic [15:0] l0 [2];
    l0[0] = 16'h1000;
    l0[1] = 16'hF000;
    exp_q.push_back(mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0100));
    exp_q.push_back(mk(16'h8000, 16'h0000, 16'h0000, 16'h0100));
    for (int r = 0; r < 2; r++) begin
      start_run(mk(16'h1000, 16'h0000, 16'h0000, 16'h0100), mk(l0[r], 16'h0000, 16'h0000, 16'h0100));
      wait_done(lat, pok);
      n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL sat%0d_latency got %0d exp 12", r, lat); end
      e = exp_q.pop_front();
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          n_cmp++;
          if (bus.matrix[i][j] !== e[i][j]) begin
            n_bad++; $display("FAIL sat%0d A[%0d][%0d] got %h exp %h", r, i, j, bus.matrix[i][j], e[i][j]);
          end
        end
    end
  endtask

  task automatic test_busy_start();
    int lat; int extra; mat_t e; mat_t v; mat_t l;
    v = {$urandom, $urandom};
    l = {$urandom, $urandom};
    exp_q.push_back(model(v, l));
    @(negedge clk);
    bus.eigenvectors = v; bus.eigenvalues = l; bus.start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.eigenvectors = {$urandom, $urandom};
      bus.eigenvalues  = {$urandom, $urandom};
      @(posedge clk); #1;
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_hold edge %0d got %b exp 1", n, bus.busy); end
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL busy_latency got %0d exp 12", lat); end
    // start stays high across the DONE cycle and must not relaunch.
    @(negedge clk);
    bus.eigenvectors = {$urandom, $urandom};
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done got %b exp 0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL busy_single_done extra %0d exp 0", extra); end
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (bus.matrix[i][j] !== e[i][j]) begin
          n_bad++; $display("FAIL busy_first_inputs A[%0d][%0d] got %h exp %h", i, j, bus.matrix[i][j], e[i][j]);
        end
      end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic pok; mat_t e;
    exp_q.push_back(mk(16'h02FF, 16'h00FF, 16'h00FF, 16'h02FF));
    start_run(mk(16'h00B5, 16'hFF4B, 16'h00B5, 16'h00B5), mk(16'h0400, 16'h0000, 16'h0000, 16'h0200));
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    void'(exp_q.pop_back());
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b exp 0", bus.done); end
    n_cmp++; if (bus.matrix !== '0) begin n_bad++; $display("FAIL midrst_matrix got %h exp 0", bus.matrix); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(mk(16'h02FF, 16'h00FF, 16'h00FF, 16'h02FF));
    start_run(mk(16'h00B5, 16'hFF4B, 16'h00B5, 16'h00B5), mk(16'h0400, 16'h0000, 16'h0000, 16'h0200));
    wait_done(lat, pok);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL midrst_latency got %0d exp 12", lat); end
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (bus.matrix[i][j] !== e[i][j]) begin
          n_bad++; $display("FAIL midrst_rerun A[%0d][%0d] got %h exp %h", i, j, bus.matrix[i][j], e[i][j]);
        end
      end
  endtask

  task automatic test_back_to_back();
    int lat; logic pok; mat_t e; mat_t v; mat_t l;
    exp_q.push_back(mk(16'h0200, 16'h0000, 16'h0000, 16'h0300));
    start_run(mk(16'h0100, 16'h0000, 16'h0000, 16'h0100), mk(16'h0200, 16'h0000, 16'h0000, 16'h0300));
    wait_done(lat, pok);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL b2b_first_latency got %0d exp 12", lat); end
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (bus.matrix[i][j] !== e[i][j]) begin
          n_bad++; $display("FAIL b2b_first A[%0d][%0d] got %h exp %h", i, j, bus.matrix[i][j], e[i][j]);
        end
      end
    // wait_done returns inside the first IDLE cycle, so this start is the earliest accept.
    v = {$urandom, $urandom};
    l = {$urandom, $urandom};
    exp_q.push_back(model(v, l));
    start_run(v, l);
    wait_done(lat, pok);
    n_cmp++; if (lat !== 12) begin n_bad++; $display("FAIL b2b_second_latency got %0d exp 12", lat); end
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL b2b_second_pulse got %b exp 1", pok); end
    e = exp_q.pop_front();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_cmp++;
        if (bus.matrix[i][j] !== e[i][j]) begin
          n_bad++; $display("FAIL b2b_second A[%0d][%0d] got %h exp %h", i, j, bus.matrix[i][j], e[i][j]);
        end
      end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.eigenvectors = '0;
    bus.eigenvalues  = '0;
    rst              = 1'b0;
    test_reset();
    test_identity();
    test_rotation();
    test_saturation();
    test_busy_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
